camera_sccb_config: RTL and testbench
=====================================

# camera_sccb_config

Write-only SCCB master that loads a fixed register table into the OV7670 camera after power-up or on request. It sits beside the DOWNSAMPLER / frame-buffer path and is clocked from the 25 MHz PLL output. It sequences one 3-phase write per table entry and inserts a settle delay after the camera soft reset. It reports progress so the top level can hold off frame capture until configuration is complete.

## Interface
- CLK_DIV, 63: CLOCK cycles per quarter-bit tick; SIO_C period = 4*CLK_DIV cycles (≈99 kHz at 25 MHz).
- DEVICE_ADDR, 8'h42: SCCB write ID byte.
- NUM_REGS, 8: number of table entries sent.
- RESET_DELAY, 25000: CLOCK cycles waited after a soft-reset entry (≈1 ms).
- CLOCK  in  1  system clock (25 MHz domain).
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; starts the sequence from entry 0.
- SIO_C  out  1  SCCB clock.
- SIO_D_OUT  out  1  SCCB data value when driven.
- SIO_D_OE  out  1  1 = drive SIO_D_OUT; 0 = release (don't-care bit).
- BUSY  out  1  sequence in progress.
- DONE  out  1  high after the last entry until the next START.
- REG_INDEX  out  [3:0]  index of the entry currently being sent.

## Operation
- Reset values: SIO_C=1, SIO_D_OUT=1, SIO_D_OE=1, BUSY=0, DONE=0, REG_INDEX=0, state IDLE, tick counter 0.
- Tick generator: counter 0..CLK_DIV-1, free-running only while BUSY. Tick asserts when the count equals CLK_DIV-1. Each FSM phase lasts exactly one tick.
- FSM states: IDLE → START_C → BITS → STOP_C → GAP → (DELAY) → next entry or FINISH.
  - IDLE/FINISH: accepts START; loads index 0 and enters START_C. START in any other state is ignored.
  - START_C phases (C,D): (1,1),(1,0),(1,0),(0,0).
  - BITS: 27 bits = DEVICE_ADDR, register address, data, each sent MSB first and each followed by a don't-care bit.
    - Data-bit phases (C): 0,0,1,1. D updates at phase 0 only.
    - Don't-care bit: OE=0, D_OUT=1 for all 4 phases; no ACK checked.
  - STOP_C phases (C,D): (0,0),(1,0),(1,1),(1,1).
  - GAP: 4 ticks, bus idle (1,1).
  - DELAY: entered after GAP when entry address = 8'h12 and data bit7 = 1. Waits RESET_DELAY cycles, counted in CLOCK cycles, not ticks.
- After GAP/DELAY: if REG_INDEX = NUM_REGS-1, enter FINISH (BUSY=0, DONE=1); else increment REG_INDEX and enter START_C.
- START in FINISH clears DONE in the same cycle BUSY rises.
- RESET mid-transaction: all outputs return to reset values immediately. The bus goes idle high and no partial entry resumes.

## Timing
- START sampled at posedge. BUSY=1 the following cycle. SIO_D falls CLK_DIV cycles later (START_C phase 1).
- One entry = 4+108+4+4 = 120 ticks = 120*CLK_DIV cycles (7560 at default), plus DELAY if applicable.
- Full default table: 8*7560 + 25000 = 85480 cycles from START to DONE.
- Outputs are registered; no combinational path from START to SIO pins.

## Structure
- Package camera_cfg_pkg: the SCCB phase enum, DEVICE_ADDR default, and the OV7670 register table. Entries are {addr,data}:
  - 12/80 (soft reset)
  - 12/0C (QCIF, RGB)
  - 0C/08 (scaling enable)
  - 11/C0 (external clock)
  - 40/D0 (RGB565, full range)
  - 14/0B (gain ceiling)
  - 1E/30 (mirror/flip)
  - 42/00 (color bar off)
- Sub-module camera_reg_rom: combinational 4-bit index → 16-bit {addr,data} lookup.

## Test plan
- CLK_DIV=4, pulse START → 27 SIO_C rising edges per entry. Sampled bits for entry 0 are 0x42,x,0x12,x,0x80,x; OE=0 exactly on bits 9, 18 and 27.
- Entry 0 (12/80) → DELAY lasts RESET_DELAY cycles between its STOP and the next START condition; entry 1 (12/0C) has no DELAY.
- Defaults → DONE rises 85480 cycles after START, BUSY falls the same cycle, REG_INDEX=7.
- START pulsed mid-entry 3 → ignored; sequence and final timing unchanged.
- RESET asserted during BITS of entry 2 → SIO_C=SIO_D_OUT=SIO_D_OE=1 and BUSY=0 immediately. Next START restarts at REG_INDEX=0.
- START in FINISH → DONE=0 and BUSY=1 next cycle; full table resent identically.

Source files
------------

// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the OV7670 SCCB configuration master: FSM states,
// default write ID and the register table loaded after power-up.
package camera_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_C,
    BITS,
    STOP_C,
    GAP,
    DELAY,
    FINISH
  } sccb_state_t;

  localparam logic [7:0] DEFAULT_DEVICE_ADDR = 8'h42;
  localparam int         TABLE_LEN           = 8;

  // {register address, data}
  localparam logic [15:0] REG_TABLE [TABLE_LEN] = '{
    16'h1280,  // soft reset
    16'h120C,  // QCIF, RGB
    16'h0C08,  // scaling enable
    16'h11C0,  // external clock
    16'h40D0,  // RGB565, full range
    16'h140B,  // gain ceiling
    16'h1E30,  // mirror/flip
    16'h4200   // color bar off
  };

  // COM7 with bit 7 set resets the sensor, which then needs time to settle
  function automatic logic is_soft_reset(input logic [15:0] entry);
    return (entry[15:8] == 8'h12) && entry[7];
  endfunction

endpackage

// File: rtl/camera_reg_rom.sv
// Combinational lookup of one {addr,data} configuration entry by index.
module camera_reg_rom
  import camera_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] entry
);

  always_comb begin
    entry = 16'hFFFF;
    if (index < 4'(TABLE_LEN)) begin
      entry = REG_TABLE[index[2:0]];
    end
  end

endmodule

// File: rtl/camera_sccb_config.sv
// Write-only SCCB master: sends the register table as 3-phase writes, with a
// settle delay after the soft-reset entry, and reports BUSY/DONE progress.
module camera_sccb_config
  import camera_cfg_pkg::*;
#(
  parameter int         CLK_DIV     = 63,
  parameter logic [7:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
  parameter int         NUM_REGS    = 8,
  parameter int         RESET_DELAY = 25000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  output logic       SIO_C,
  output logic       SIO_D_OUT,
  output logic       SIO_D_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] REG_INDEX
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(RESET_DELAY - 1);
  localparam logic [3:0]    LAST_INDEX = 4'(NUM_REGS - 1);

  sccb_state_t   state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [1:0]    phase_reg, phase_next;
  logic [3:0]    bit_reg, bit_next;
  logic [1:0]    byte_reg, byte_next;
  logic [DW-1:0] delay_reg, delay_next;
  logic [3:0]    index_reg, index_next;
  logic          sio_c_next, sio_d_next, sio_oe_next;
  logic [15:0]   entry;
  logic [7:0]    cur_byte;
  logic          tick, ticking;

  camera_reg_rom u_rom (
    .index (index_reg),
    .entry (entry)
  );

  assign tick    = (tick_reg == TICK_LAST);
  assign ticking = (state_reg == START_C) || (state_reg == BITS) ||
                   (state_reg == STOP_C)  || (state_reg == GAP);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    delay_next = delay_reg;
    index_next = index_reg;
    tick_next  = (ticking && !tick) ? tick_reg + TW'(1) : '0;

    case (state_reg)
      IDLE, FINISH: begin
        if (START) begin
          state_next = START_C;
          phase_next = '0;
          bit_next   = '0;
          byte_next  = '0;
          index_next = '0;
        end
      end
      START_C, STOP_C: begin
        if (tick) begin
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) begin
            state_next = (state_reg == START_C) ? BITS : GAP;
          end
        end
      end
      BITS: begin
        if (tick) begin
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) begin
            if (bit_reg == 4'd8) begin
              bit_next  = '0;
              byte_next = byte_reg + 2'd1;
              if (byte_reg == 2'd2) begin
                byte_next  = '0;
                state_next = STOP_C;
              end
            end else begin
              bit_next = bit_reg + 4'd1;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) begin
            if (is_soft_reset(entry)) begin
              state_next = DELAY;
              delay_next = '0;
            end else if (index_reg == LAST_INDEX) begin
              state_next = FINISH;
            end else begin
              index_next = index_reg + 4'd1;
              state_next = START_C;
            end
          end
        end
      end
      DELAY: begin
        delay_next = delay_reg + DW'(1);
        if (delay_reg == DELAY_LAST) begin
          phase_next = '0;
          if (index_reg == LAST_INDEX) begin
            state_next = FINISH;
          end else begin
            index_next = index_reg + 4'd1;
            state_next = START_C;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they leave a flop directly
  always_comb begin
    sio_c_next  = 1'b1;
    sio_d_next  = 1'b1;
    sio_oe_next = 1'b1;
    case (byte_next)
      2'd0:    cur_byte = DEVICE_ADDR;
      2'd1:    cur_byte = entry[15:8];
      default: cur_byte = entry[7:0];
    endcase
    case (state_next)
      START_C: begin
        sio_c_next = (phase_next != 2'd3);
        sio_d_next = (phase_next == 2'd0);
      end
      BITS: begin
        sio_c_next = phase_next[1];
        if (bit_next == 4'd8) begin
          sio_oe_next = 1'b0;
        end else begin
          sio_d_next = cur_byte[3'd7 - bit_next[2:0]];
        end
      end
      STOP_C: begin
        sio_c_next = (phase_next != 2'd0);
        sio_d_next = phase_next[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      phase_reg <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      delay_reg <= '0;
      index_reg <= '0;
      SIO_C     <= 1'b1;
      SIO_D_OUT <= 1'b1;
      SIO_D_OE  <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      delay_reg <= delay_next;
      index_reg <= index_next;
      SIO_C     <= sio_c_next;
      SIO_D_OUT <= sio_d_next;
      SIO_D_OE  <= sio_oe_next;
      BUSY      <= (state_next != IDLE) && (state_next != FINISH);
      DONE      <= (state_next == FINISH);
    end
  end

  assign REG_INDEX = index_reg;

endmodule

// File: tb/tb_camera_sccb_config.sv
// Self-checking bench: decodes SCCB frames off the pins and compares them and
// their timing against a hand-written table of expected register writes.
module tb_camera_sccb_config;

  localparam int CLK_DIV     = 4;
  localparam int RESET_DELAY = 100;
  localparam int NUM_REGS    = 8;
  // 120 ticks per entry, plus the settle delay after the soft reset
  localparam int TOTAL       = NUM_REGS * 120 * CLK_DIV + RESET_DELAY;
  // STOP D-rise to next START D-fall: STOP ph2,ph3 + 4 GAP + START_C ph0 = 7 ticks
  localparam int STOP_TO_START = 7 * CLK_DIV;

  logic       clk, rst, start;
  logic       sio_c, sio_d, sio_oe, busy, done;
  logic [3:0] reg_index;

  camera_sccb_config #(
    .CLK_DIV     (CLK_DIV),
    .DEVICE_ADDR (8'h42),
    .NUM_REGS    (NUM_REGS),
    .RESET_DELAY (RESET_DELAY)
  ) dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .START     (start),
    .SIO_C     (sio_c),
    .SIO_D_OUT (sio_d),
    .SIO_D_OE  (sio_oe),
    .BUSY      (busy),
    .DONE      (done),
    .REG_INDEX (reg_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t tab [NUM_REGS];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Bus monitor, sampled on the falling clock edge
  logic [26:0] frame_d   [64];
  logic [26:0] frame_oe  [64];
  int          frame_edges [64];
  int          start_cyc [64];
  int          stop_cyc  [64];
  int          frame_cnt = 0;
  int          edge_cnt  = 0;
  logic [26:0] cur_d = '0, cur_oe = '0;
  logic        prev_c = 1'b1, prev_d = 1'b1;

  always @(negedge clk) begin
    if (!prev_c && sio_c) begin
      if (edge_cnt < 27) begin
        cur_d  = {cur_d[25:0], sio_d};
        cur_oe = {cur_oe[25:0], sio_oe};
      end
      edge_cnt++;
    end
    if (prev_c && sio_c && prev_d && !sio_d) begin
      edge_cnt = 0;
      cur_d    = '0;
      cur_oe   = '0;
      if (frame_cnt < 64) start_cyc[frame_cnt] = cyc;
    end
    if (prev_c && sio_c && !prev_d && sio_d && frame_cnt < 64) begin
      frame_d[frame_cnt]     = cur_d;
      frame_oe[frame_cnt]    = cur_oe;
      frame_edges[frame_cnt] = edge_cnt;
      stop_cyc[frame_cnt]    = cyc;
      frame_cnt++;
    end
    prev_c = sio_c;
    prev_d = sio_d;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input bit mid_pulse);
    int cnt;
    bit pulsed;
    cnt = 0;
    pulsed = 0;
    while (!done && cnt < TOTAL + 500) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (mid_pulse && !pulsed && reg_index == 4'd3 && edge_cnt > 3 && edge_cnt < 20) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (cnt == CLK_DIV - 1) check("sda_before_fall", sio_d, 1);
      if (cnt == CLK_DIV)     check("sda_start_fall", sio_d, 0);
    end
    start = 1'b0;
    check("done_latency", cnt, TOTAL);
    check("done_high", done, 1);
    check("busy_low_at_done", busy, 0);
    check("final_index", reg_index, 4'd7);
    if (mid_pulse) check("mid_start_issued", pulsed, 1);
  endtask

  task automatic check_frames(input int base);
    logic [26:0] exp_d;
    logic [26:0] exp_oe;
    check("frame_count", frame_cnt - base, NUM_REGS);
    exp_oe = {9'h1FE, 9'h1FE, 9'h1FE};
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_d = {8'h42, 1'b1, tab[i].addr, 1'b1, tab[i].data, 1'b1};
      check($sformatf("frame%0d_bits", i), frame_d[base + i], exp_d);
      check($sformatf("frame%0d_oe", i), frame_oe[base + i], exp_oe);
      // 27 bit clocks plus the rising edge of the STOP condition
      check($sformatf("frame%0d_bit_clocks", i), frame_edges[base + i] - 1, 27);
    end
  endtask

  initial begin
    int base;
    int guard;

    tab[0] = '{8'h12, 8'h80};
    tab[1] = '{8'h12, 8'h0C};
    tab[2] = '{8'h0C, 8'h08};
    tab[3] = '{8'h11, 8'hC0};
    tab[4] = '{8'h40, 8'hD0};
    tab[5] = '{8'h14, 8'h0B};
    tab[6] = '{8'h1E, 8'h30};
    tab[7] = '{8'h42, 8'h00};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d", sio_d, 1);
    check("rst_sio_oe", sio_oe, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", reg_index, 0);
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Run A: plain sequence from IDLE
    base = frame_cnt;
    pulse_start();
    check("a_busy_rise", busy, 1);
    check("a_done_low", done, 0);
    check("a_index0", reg_index, 0);
    wait_done(0);
    check_frames(base);
    check("delay_after_soft_reset", start_cyc[base + 1] - stop_cyc[base], STOP_TO_START + RESET_DELAY);
    check("no_delay_entry1", start_cyc[base + 2] - stop_cyc[base + 1], STOP_TO_START);

    // Run B: restart from FINISH, with a stray START during entry 3
    repeat (3) @(negedge clk);
    base = frame_cnt;
    pulse_start();
    check("b_done_cleared", done, 0);
    check("b_busy_rise", busy, 1);
    wait_done(1);
    check_frames(base);

    // Run C: reset during BITS of entry 2, then restart
    repeat (3) @(negedge clk);
    pulse_start();
    guard = 0;
    while (!(reg_index == 4'd2 && edge_cnt >= 5 && edge_cnt < 20) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reset_window_reached", guard < 3000, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_sio_c", sio_c, 1);
    check("mid_rst_sio_d", sio_d, 1);
    check("mid_rst_sio_oe", sio_oe, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_index", reg_index, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    base = frame_cnt;
    pulse_start();
    check("c_index0", reg_index, 0);
    check("c_busy_rise", busy, 1);
    wait_done(0);
    check_frames(base);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
